// File: rtl/noc_packetizer_if.sv
// AXI-Stream style channel used for raw payload input and the routed packet output.
// 'm' drives the stream, 's' consumes it.
interface axis_if #(
   parameter int DATA_WIDTH = 32
) ();
   logic                  TVALID;
   logic                  TREADY;
   logic [DATA_WIDTH-1:0] TDATA;
   logic                  TLAST;

   modport m (output TVALID, TDATA, TLAST, input TREADY);
   modport s (input TVALID, TDATA, TLAST, output TREADY);
endinterface

// File: rtl/noc_packetizer.sv
// NoC transmit interface: one command plus a raw payload stream become a routed packet
// made of a routing-header flit followed by exactly cmd_len type-tagged payload flits.
package noc_pkg;
   localparam int PACKET_TYPE_WIDTH = 2;
   localparam logic [PACKET_TYPE_WIDTH-1:0] ROUTING_HEADER = 2'b11;
endpackage

module noc_packetizer
   import noc_pkg::*;
#(
   parameter int DATA_WIDTH              = 32,
   parameter int MAX_ROUTERS_X           = 4,
   parameter int MAX_ROUTERS_Y           = 4,
   parameter int MAXIMUM_PACKAGES_NUMBER = 5,
   parameter int PAYLOAD_TYPE            = 0,
   localparam int MAX_ROUTERS_X_WIDTH           = $clog2(MAX_ROUTERS_X),
   localparam int MAX_ROUTERS_Y_WIDTH           = $clog2(MAX_ROUTERS_Y),
   localparam int MAXIMUM_PACKAGES_NUMBER_WIDTH = $clog2(MAXIMUM_PACKAGES_NUMBER-1)
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic [MAX_ROUTERS_X_WIDTH-1:0]           own_x,
   input  logic [MAX_ROUTERS_Y_WIDTH-1:0]           own_y,
   input  logic                                     cmd_valid,
   output logic                                     cmd_ready,
   input  logic [MAX_ROUTERS_X_WIDTH-1:0]           cmd_dest_x,
   input  logic [MAX_ROUTERS_Y_WIDTH-1:0]           cmd_dest_y,
   input  logic [MAXIMUM_PACKAGES_NUMBER_WIDTH-1:0] cmd_len,
   output logic                                     err_len,
   axis_if.s                                        in,
   axis_if.m                                        out
);
   localparam int XW  = MAX_ROUTERS_X_WIDTH;
   localparam int YW  = MAX_ROUTERS_Y_WIDTH;
   localparam int P   = MAXIMUM_PACKAGES_NUMBER_WIDTH;
   localparam int DW  = DATA_WIDTH;
   localparam int PTW = PACKET_TYPE_WIDTH;
   localparam logic [PTW-1:0] PLD_TYPE = PTW'(PAYLOAD_TYPE);
   // Idle pattern keeps a payload type visible so the router never sees a stale header.
   localparam logic [DW-1:0]  IDLE_PAT = {PLD_TYPE, {(DW-PTW){1'b0}}};

   if (XW != YW) begin : g_bad_xy
      $error("noc_packetizer: X and Y coordinate widths differ");
   end
   if (PLD_TYPE == ROUTING_HEADER) begin : g_bad_type
      $error("noc_packetizer: PAYLOAD_TYPE aliases ROUTING_HEADER");
   end
   if (2*(XW+YW)+P > DW-PTW) begin : g_bad_width
      $error("noc_packetizer: header fields do not fit in DATA_WIDTH");
   end

   typedef enum logic {IDLE, PLD} state_t;

   state_t          state, state_nxt;
   logic [P-1:0]    remaining;
   logic            o_valid, o_last;
   logic [DW-1:0]   o_data;
   logic            load_ok, cmd_hs, in_hs, load_hdr, load_pld, last_pld;
   logic [DW-1:0]   hdr_flit, pld_flit;
   logic            unused_in;

   assign load_ok  = !o_valid || out.TREADY;
   assign cmd_hs   = cmd_valid && cmd_ready;
   assign in_hs    = in.TVALID && in.TREADY;
   assign load_hdr = cmd_hs && (cmd_len != '0);
   assign load_pld = in_hs;
   assign last_pld = (remaining == P'(1));

   // Packet length comes only from cmd_len; upstream TLAST and the raw type bits are dropped.
   assign unused_in = ^{in.TLAST, in.TDATA[DW-1 -: PTW]};

   always_comb begin
      hdr_flit = '0;
      hdr_flit[DW-1 -: PTW]                = ROUTING_HEADER;
      hdr_flit[XW-1:0]                     = cmd_dest_y;
      hdr_flit[XW+YW-1:XW]                 = cmd_dest_x;
      hdr_flit[XW+2*YW-1:XW+YW]            = own_y;
      hdr_flit[2*(XW+YW)-1:XW+2*YW]        = own_x;
      hdr_flit[2*(XW+YW)+P-1:2*(XW+YW)]    = cmd_len;
   end

   assign pld_flit = {PLD_TYPE, in.TDATA[DW-PTW-1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cmd_ready = 1'b0;
      in.TREADY = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = load_ok;
            if (load_hdr) state_nxt = PLD;
         end
         PLD: begin
            in.TREADY = load_ok;
            if (in_hs && last_pld) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         remaining <= '0;
         o_valid   <= 1'b0;
         o_last    <= 1'b0;
         o_data    <= IDLE_PAT;
         err_len   <= 1'b0;
      end else begin
         err_len <= cmd_hs && (cmd_len == '0);
         if (load_hdr) begin
            o_valid   <= 1'b1;
            o_last    <= 1'b0;
            o_data    <= hdr_flit;
            remaining <= cmd_len;
         end else if (load_pld) begin
            o_valid   <= 1'b1;
            o_last    <= last_pld;
            o_data    <= pld_flit;
            remaining <= remaining - P'(1);
         end else if (out.TREADY) begin
            o_valid <= 1'b0;
            o_last  <= 1'b0;
            o_data  <= IDLE_PAT;
         end
      end
   end

   assign out.TVALID = o_valid;
   assign out.TDATA  = o_data;
   assign out.TLAST  = o_last;
endmodule

// File: tb/tb_noc_packetizer.sv
// Bench for noc_packetizer: directed and random packets against a queue-based packet model.
module tb_noc_packetizer;
   import noc_pkg::*;

   localparam int DW = 32, XW = 2, YW = 2, P = 2, PTW = PACKET_TYPE_WIDTH;
   localparam logic [PTW-1:0] RH = ROUTING_HEADER;
   localparam logic [31:0] PT = 32'd0;
   localparam logic [31:0] IDLE_PAT = PT << (DW-PTW);
   localparam logic [31:0] LOW_MASK = (32'h1 << (DW-PTW)) - 32'h1;

   typedef struct {
      logic [1:0] dx, dy, len;
   } cmd_t;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [XW-1:0] own_x, own_y, cmd_dest_x;
   logic [YW-1:0] cmd_dest_y;
   logic [P-1:0]  cmd_len;
   logic          cmd_valid, cmd_ready, err_len;

   axis_if #(.DATA_WIDTH(DW)) in_if ();
   axis_if #(.DATA_WIDTH(DW)) out_if ();

   noc_packetizer dut (
      .clk(clk), .rst_n(rst_n), .own_x(own_x), .own_y(own_y),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dest_x(cmd_dest_x),
      .cmd_dest_y(cmd_dest_y), .cmd_len(cmd_len), .err_len(err_len),
      .in(in_if), .out(out_if)
   );

   int checks = 0, failures = 0, cyc = 0;
   cmd_t        cq[$];
   logic [31:0] pq[$], exp_d[$], got_d[$];
   bit          exp_l[$], got_l[$];
   int          got_c[$], acc_q[$], err_cyc[$];
   int          err_seen = 0, exp_err = 0, stall_start = -100;
   bit          stall_en = 0, rnd_ready = 0, rnd_gaps = 0;
   logic        pv = 0, pr = 0, pl = 0;
   logic [31:0] pd = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   always @(posedge clk) cyc = cyc + 1;

   // Output monitor: records handshaken flits and checks idle pattern and hold-under-stall.
   always @(negedge clk) begin
      if (!rst_n) begin
         pv = 0;
      end else begin
         if (out_if.TVALID && out_if.TREADY) begin
            got_d.push_back(out_if.TDATA);
            got_l.push_back(out_if.TLAST);
            got_c.push_back(cyc);
         end
         if (err_len) begin
            err_seen++;
            err_cyc.push_back(cyc);
         end
         if (!out_if.TVALID) chk("idle_pattern", out_if.TDATA, IDLE_PAT);
         if (pv && !pr) begin
            chk("hold_valid", out_if.TVALID, 1'b1);
            chk("hold_data", out_if.TDATA, pd);
            chk("hold_last", out_if.TLAST, pl);
         end
         pv = out_if.TVALID; pr = out_if.TREADY; pd = out_if.TDATA; pl = out_if.TLAST;
      end
   end

   function automatic logic [31:0] hdr_word(int dx, int dy, int len, int ox, int oy);
      return (32'(RH) << (DW-PTW)) | 32'(len << (2*(XW+YW))) | 32'(ox << (XW+2*YW))
           | 32'(oy << (XW+YW)) | 32'(dx << XW) | 32'(dy);
   endfunction

   task automatic queue_cmd(input int dx, input int dy, input int len,
                            input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
      logic [31:0] w[3];
      cmd_t c;
      w[0] = w0; w[1] = w1; w[2] = w2;
      c.dx = 2'(dx); c.dy = 2'(dy); c.len = 2'(len);
      cq.push_back(c);
      if (len == 0) begin
         exp_err++;
      end else begin
         exp_d.push_back(hdr_word(dx, dy, len, int'(own_x), int'(own_y)));
         exp_l.push_back(1'b0);
         for (int i = 0; i < len; i++) begin
            pq.push_back(w[i]);
            exp_d.push_back((PT << (DW-PTW)) | (w[i] & LOW_MASK));
            exp_l.push_back(i == len-1);
         end
      end
   endtask

   task automatic drive();
      cmd_valid  = (cq.size() != 0);
      cmd_dest_x = cq.size() != 0 ? cq[0].dx  : 2'd0;
      cmd_dest_y = cq.size() != 0 ? cq[0].dy  : 2'd0;
      cmd_len    = cq.size() != 0 ? cq[0].len : 2'd0;
      in_if.TVALID = (pq.size() != 0) && (!rnd_gaps || ($urandom % 4 != 0));
      in_if.TDATA  = pq.size() != 0 ? pq[0] : 32'h0;
      in_if.TLAST  = (pq.size() == 1);
      if (rnd_ready) out_if.TREADY = ($urandom % 4 != 0);
      else           out_if.TREADY = !(cyc >= stall_start && cyc < stall_start + 3);
   endtask

   task automatic step();
      bit c_hs, i_hs;
      @(negedge clk);
      c_hs = cmd_valid && cmd_ready;
      i_hs = in_if.TVALID && in_if.TREADY;
      if (c_hs) begin
         acc_q.push_back(cyc);
         if (stall_en) begin stall_start = cyc + 3; stall_en = 0; end
      end
      if (out_if.TVALID && !out_if.TREADY) begin
         chk("stall_in_tready", in_if.TREADY, 1'b0);
         chk("stall_cmd_ready", cmd_ready, 1'b0);
      end
      @(posedge clk); #1;
      if (c_hs) void'(cq.pop_front());
      if (i_hs) void'(pq.pop_front());
      drive();
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while ((cq.size() != 0 || pq.size() != 0 || got_d.size() < exp_d.size()) && n < budget) begin
         step(); n++;
      end
      chk({tag, "_timeout"}, n < budget, 1'b1);
      repeat (4) step();
   endtask

   task automatic compare_stream(input string tag);
      chk({tag, "_count"}, got_d.size(), exp_d.size());
      for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
         chk({tag, "_data"}, got_d[i], exp_d[i]);
         chk({tag, "_last"}, got_l[i], exp_l[i]);
      end
      chk({tag, "_err"}, err_seen, exp_err);
   endtask

   task automatic clear_sb();
      cq.delete(); pq.delete(); exp_d.delete(); exp_l.delete();
      got_d.delete(); got_l.delete(); got_c.delete(); acc_q.delete(); err_cyc.delete();
      err_seen = 0; exp_err = 0;
   endtask

   initial begin
      own_x = 0; own_y = 0; cmd_valid = 0; cmd_dest_x = 0; cmd_dest_y = 0; cmd_len = 0;
      in_if.TVALID = 0; in_if.TDATA = 0; in_if.TLAST = 0; out_if.TREADY = 1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", out_if.TVALID, 1'b0);
      chk("rst_tlast", out_if.TLAST, 1'b0);
      chk("rst_tdata", out_if.TDATA, IDLE_PAT);
      chk("rst_cmd_ready", cmd_ready, 1'b1);
      chk("rst_in_tready", in_if.TREADY, 1'b0);
      chk("rst_err_len", err_len, 1'b0);
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1; drive();

      // Basic len-3 packet, sink always ready
      queue_cmd(2, 1, 3, 32'hA, 32'hB, 32'hC);
      drain("t1", 40);
      compare_stream("t1");
      if (got_d.size() == 4 && acc_q.size() == 1) begin
         chk("t1_hdr_type", got_d[0][31:30], RH);
         chk("t1_hdr_dx", got_d[0][3:2], 2'd2);
         chk("t1_hdr_dy", got_d[0][1:0], 2'd1);
         chk("t1_hdr_src", got_d[0][7:4], 4'd0);
         chk("t1_hdr_len", got_d[0][9:8], 2'd3);
         for (int i = 0; i < 4; i++) chk("t1_cycle", got_c[i], acc_q[0] + 1 + i);
      end else chk("t1_shape", got_d.size() * 10 + acc_q.size(), 41);
      clear_sb();

      // Same packet with a 3-cycle sink stall on payload 2
      stall_en = 1;
      queue_cmd(2, 1, 3, 32'hA, 32'hB, 32'hC);
      drain("t2", 40);
      compare_stream("t2");
      clear_sb(); stall_start = -100;

      // Two len-1 packets back-to-back
      queue_cmd(3, 0, 1, 32'h1111_0001, 0, 0);
      queue_cmd(0, 3, 1, 32'h2222_0002, 0, 0);
      drain("t3", 40);
      compare_stream("t3");
      if (got_c.size() == 4 && acc_q.size() == 2) begin
         for (int i = 0; i < 4; i++) chk("t3_cycle", got_c[i], acc_q[0] + 1 + i);
         chk("t3_cmd2_accept", acc_q[1], acc_q[0] + 2);
      end else chk("t3_shape", got_c.size() * 10 + acc_q.size(), 42);
      clear_sb();

      // Zero-length command, then two back-to-back
      queue_cmd(1, 1, 0, 0, 0, 0);
      drain("t4a", 20);
      compare_stream("t4a");
      if (err_cyc.size() == 1 && acc_q.size() == 1) chk("t4a_err_cyc", err_cyc[0], acc_q[0] + 1);
      clear_sb();
      queue_cmd(1, 2, 0, 0, 0, 0);
      queue_cmd(2, 1, 0, 0, 0, 0);
      drain("t4b", 20);
      compare_stream("t4b");
      if (err_cyc.size() == 2 && acc_q.size() == 2) begin
         chk("t4b_err_consec", err_cyc[1], err_cyc[0] + 1);
         chk("t4b_cmd_consec", acc_q[1], acc_q[0] + 1);
      end
      clear_sb();

      // Payload whose top bits look like a routing header
      queue_cmd(1, 2, 1, 32'hC000_1234, 0, 0);
      drain("t5", 30);
      compare_stream("t5");
      if (got_d.size() == 2) chk("t5_alias", got_d[1], 32'h0000_1234);
      clear_sb();

      // Asynchronous reset in the middle of a len-3 packet
      queue_cmd(1, 3, 3, 32'h5, 32'h6, 32'h7);
      for (int n = 0; n < 20 && got_d.size() < 2; n++) step();
      chk("t6_reached_payload", got_d.size() >= 2, 1'b1);
      #2; rst_n = 0; #1;
      chk("t6_rst_tvalid", out_if.TVALID, 1'b0);
      chk("t6_rst_tdata", out_if.TDATA, IDLE_PAT);
      chk("t6_rst_cmd_ready", cmd_ready, 1'b1);
      chk("t6_rst_in_tready", in_if.TREADY, 1'b0);
      clear_sb(); drive();
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(posedge clk); #1;
      clear_sb(); drive();
      queue_cmd(2, 2, 2, 32'hDEAD_BEEF, 32'h1234_5678, 0);
      drain("t6", 40);
      compare_stream("t6");
      clear_sb();

      // Random commands, random source gaps and sink backpressure
      rnd_ready = 1; rnd_gaps = 1;
      for (int r = 0; r < 3; r++) begin
         own_x = 2'($urandom); own_y = 2'($urandom);
         for (int k = 0; k < 6; k++)
            queue_cmd(int'($urandom % 4), int'($urandom % 4), int'($urandom % 4),
                      $urandom, $urandom, $urandom);
         drain("rnd", 600);
         compare_stream("rnd");
         clear_sb();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
